// File: rtl/fft_frame_sequencer.sv
// Trigger FFT path sequencer: configures the xfft core once per reset, then streams a
// 64-sample frame from block RAM into the FFT. Optional macro FFT_SEQ_BITREV_EN reads RAM in bit-reversed order.
module fft_frame_sequencer #(
   parameter int         DATA_W   = 32,
   parameter int         ADDR_W   = 6,
   parameter logic [7:0] CFG_WORD = 8'h01
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_ready,
   output logic              frame_busy,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [7:0]        cfg_tdata,
   output logic              cfg_tvalid,
   input  logic              cfg_tready,
   output logic [DATA_W-1:0] data_tdata,
   output logic              data_tvalid,
   input  logic              data_tready,
   output logic              data_tlast,
   input  logic              out_tvalid,
   input  logic              out_tready,
   input  logic              out_tlast,
   output logic              frame_done,
   output logic [7:0]        drop_count
);

   typedef enum logic [1:0] {CFG, IDLE, LOAD, DRAIN} state_t;

   localparam logic [ADDR_W-1:0] LAST_BEAT = '1;

   state_t                       state;
   logic [ADDR_W:0]              rd_idx;
   logic [ADDR_W-1:0]            beat_cnt;
   logic                         rd_vld;
   logic [1:0]                   fifo_cnt;
   logic [1:0][DATA_W-1:0]       fifo_q;
   logic                         pending;

   logic [2:0]                   occ;
   logic                         rd_issue;
   logic                         beat_xfer;
   logic                         out_last;
   logic                         drop;

   // A returning read counts as a FIFO entry so the first sample is presented
   // straight from ram_dout; this keeps first-beat latency at two cycles.
   assign occ       = {1'b0, fifo_cnt} + {2'b00, rd_vld};
   assign rd_issue  = (state == LOAD) && !rd_idx[ADDR_W] && (occ < 3'd2);
   assign beat_xfer = data_tvalid && data_tready;
   assign out_last  = out_tvalid && out_tready && out_tlast;
   assign drop      = frame_ready &&
                      ((state == CFG) || (((state == LOAD) || (state == DRAIN)) && pending));

   assign cfg_tdata   = CFG_WORD;
   assign data_tvalid = (state == LOAD) && ((fifo_cnt != 2'd0) || rd_vld);
   assign data_tdata  = !data_tvalid ? '0 : ((fifo_cnt != 2'd0) ? fifo_q[0] : ram_dout);
   assign data_tlast  = data_tvalid && (beat_cnt == LAST_BEAT);

`ifdef FFT_SEQ_BITREV_EN
   for (genvar i = 0; i < ADDR_W; i++) begin : g_bitrev
      assign ram_addr[i] = rd_idx[ADDR_W-1-i];
   end
`else
   assign ram_addr = rd_idx[ADDR_W-1:0];
`endif

   always_ff @(posedge clk) begin
      frame_done <= 1'b0;
      if (reset) begin
         state      <= CFG;
         cfg_tvalid <= 1'b1;
         frame_busy <= 1'b0;
         rd_idx     <= '0;
         beat_cnt   <= '0;
         rd_vld     <= 1'b0;
         fifo_cnt   <= 2'd0;
         fifo_q     <= '0;
         pending    <= 1'b0;
         drop_count <= 8'd0;
      end else begin
         rd_vld <= rd_issue;
         if (rd_issue)  rd_idx   <= rd_idx + 1'b1;
         if (beat_xfer) beat_cnt <= beat_cnt + 1'b1;

         // Read-return push vs. stream pop; both at once with an empty FIFO is a pass-through.
         case ({rd_vld, beat_xfer})
            2'b10: begin
               fifo_q[fifo_cnt[0]] <= ram_dout;
               fifo_cnt            <= fifo_cnt + 1'b1;
            end
            2'b01: begin
               fifo_q[0] <= fifo_q[1];
               fifo_cnt  <= fifo_cnt - 1'b1;
            end
            2'b11: if (fifo_cnt != 2'd0) fifo_q[0] <= ram_dout;
            default: ;
         endcase

         if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;

         case (state)
            CFG: if (cfg_tready) begin
               state      <= IDLE;
               cfg_tvalid <= 1'b0;
            end
            IDLE: if (frame_ready) begin
               state      <= LOAD;
               frame_busy <= 1'b1;
               rd_idx     <= '0;
               beat_cnt   <= '0;
            end
            LOAD: begin
               if (frame_ready) pending <= 1'b1;
               if (beat_xfer && data_tlast) state <= DRAIN;
            end
            DRAIN: begin
               if (frame_ready) pending <= 1'b1;
               if (out_last) begin
                  frame_done <= 1'b1;
                  if (pending || frame_ready) begin
                     state    <= LOAD;
                     pending  <= 1'b0;
                     rd_idx   <= '0;
                     beat_cnt <= '0;
                  end else begin
                     state      <= IDLE;
                     frame_busy <= 1'b0;
                  end
               end
            end
            default: state <= CFG;
         endcase
      end
   end

endmodule
